// File: rtl/spi_reg_slave.sv
// Write-only SPI mode-0 register slave owning the five pwm_peripheral configuration registers.
// Async pins are synchronised into clk; a register is written only for a complete 16-bit frame.
`timescale 1ns/1ps
module spi_reg_slave #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [6:0]  MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe
);

  localparam int unsigned NumRegs  = 5;
  localparam logic [4:0]  FrameLen = 5'd16;
  localparam logic [4:0]  CountMax = 5'd31;

  typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

  // Input synchronisers
  logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, ncs_sync_q;
  logic                   sclk_s, copi_s, ncs_s;
  logic                   sclk_d_q, ncs_d_q;
  logic                   sclk_rise, ncs_fall, ncs_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '1;
      sclk_d_q    <= 1'b0;
      ncs_d_q     <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
      sclk_d_q    <= sclk_s;
      ncs_d_q     <= ncs_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s    = copi_sync_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d_q;
  assign ncs_fall  = ~ncs_s & ncs_d_q;
  assign ncs_rise  = ncs_s & ~ncs_d_q;

  // Frame FSM
  state_e      state_q, state_d;
  logic [15:0] shift_q, shift_d;
  logic [4:0]  count_q, count_d;
  logic        fall_pend_q, fall_pend_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      count_q     <= '0;
      fall_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      count_q     <= count_d;
      fall_pend_q <= fall_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    count_d     = count_q;
    fall_pend_d = fall_pend_q;
    unique case (state_q)
      StIdle: begin
        if (ncs_fall || fall_pend_q) begin
          shift_d     = '0;
          count_d     = '0;
          fall_pend_d = 1'b0;
          state_d     = StShift;
        end
      end
      StShift: begin
        // nCS rising wins over a coincident SCLK edge
        if (ncs_rise) begin
          state_d = (count_q == FrameLen) ? StCommit : StIdle;
        end else if (sclk_rise && !ncs_s) begin
          if (count_q < FrameLen) begin
            shift_d = {shift_q[14:0], copi_s};
          end
          if (count_q != CountMax) begin
            count_d = count_q + 5'd1;
          end
        end
      end
      StCommit: begin
        state_d = StIdle;
        // Remember a frame start that lands in the commit cycle
        if (ncs_fall) begin
          fall_pend_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Register file
  logic       frame_wr;
  logic [6:0] frame_addr;
  logic [7:0] frame_data;
  logic       wr_hit;

  assign frame_wr   = shift_q[15];
  assign frame_addr = shift_q[14:8];
  assign frame_data = shift_q[7:0];
  assign wr_hit     = (state_q == StCommit) && frame_wr && (frame_addr <= MAX_ADDR)
                      && (frame_addr < 7'(NumRegs));
  assign wr_strobe  = wr_hit;

  logic [7:0] out_lo_q, out_hi_q, pwm_lo_q, pwm_hi_q, duty_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_lo_q <= '0;
      out_hi_q <= '0;
      pwm_lo_q <= '0;
      pwm_hi_q <= '0;
      duty_q   <= '0;
    end else if (wr_hit) begin
      case (frame_addr[2:0])
        3'd0:    out_lo_q <= frame_data;
        3'd1:    out_hi_q <= frame_data;
        3'd2:    pwm_lo_q <= frame_data;
        3'd3:    pwm_hi_q <= frame_data;
        3'd4:    duty_q   <= frame_data;
        default: ;
      endcase
    end
  end

  assign en_reg_out_7_0  = out_lo_q;
  assign en_reg_out_15_8 = out_hi_q;
  assign en_reg_pwm_7_0  = pwm_lo_q;
  assign en_reg_pwm_15_8 = pwm_hi_q;
  assign pwm_duty_cycle  = duty_q;

endmodule
